// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between imem read and the decode pipeline register.
// Optional zero-latency bypass of an empty queue: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int I_W   = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             fq_clk,
  input  logic             fq_rst,
  input  logic             fq_i_valid,
  input  logic [PC_W-1:0]  fq_i_pc,
  input  logic [I_W-1:0]   fq_i_instr,
  output logic             fq_o_ready,
  input  logic             fq_i_stall,
  input  logic             fq_i_flush,
  output logic             fq_o_valid,
  output logic [PC_W-1:0]  fq_o_pc,
  output logic [I_W-1:0]   fq_o_instr,
  output logic [CNT_W-1:0] fq_o_count,
  output logic             fq_o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [I_W-1:0]  instr;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              empty, full, push, pop, bypass_take;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A bypassed, unstalled instruction goes straight to decode and never occupies a slot.
`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_take = empty & fq_i_valid & ~fq_i_flush & ~fq_i_stall;
`else
  assign bypass_take = 1'b0;
`endif

  assign push = fq_i_valid & ~full & ~bypass_take;
  assign pop  = ~empty & ~fq_i_stall;

  assign fq_o_ready    = ~full;
  assign fq_o_count    = count_q;
  assign fq_o_overflow = overflow_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    fq_o_valid = 1'b0;
    fq_o_pc    = '0;
    fq_o_instr = '0;
    if (!empty) begin
      fq_o_valid = 1'b1;
      fq_o_pc    = mem_q[rd_ptr_q].pc;
      fq_o_instr = mem_q[rd_ptr_q].instr;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (fq_i_valid && !fq_i_flush) begin
      fq_o_valid = 1'b1;
      fq_o_pc    = fq_i_pc;
      fq_o_instr = fq_i_instr;
    end
`endif
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (fq_i_valid & full);
    if (fq_i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge fq_clk) begin
    if (fq_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale contents are never observed.
  always_ff @(posedge fq_clk) begin
    if (!fq_rst && !fq_i_flush && push) begin
      mem_q[wr_ptr_q] <= '{pc: fq_i_pc, instr: fq_i_instr};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios then random traffic
// against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int I_W   = 32;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             fq_clk = 1'b0;
  logic             fq_rst, fq_i_valid, fq_i_stall, fq_i_flush;
  logic [PC_W-1:0]  fq_i_pc;
  logic [I_W-1:0]   fq_i_instr;
  logic             fq_o_ready, fq_o_valid, fq_o_overflow;
  logic [PC_W-1:0]  fq_o_pc;
  logic [I_W-1:0]   fq_o_instr;
  logic [CNT_W-1:0] fq_o_count;

  fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .I_W(I_W), .CNT_W(CNT_W)) dut (
    .fq_clk(fq_clk), .fq_rst(fq_rst),
    .fq_i_valid(fq_i_valid), .fq_i_pc(fq_i_pc), .fq_i_instr(fq_i_instr),
    .fq_o_ready(fq_o_ready), .fq_i_stall(fq_i_stall), .fq_i_flush(fq_i_flush),
    .fq_o_valid(fq_o_valid), .fq_o_pc(fq_o_pc), .fq_o_instr(fq_o_instr),
    .fq_o_count(fq_o_count), .fq_o_overflow(fq_o_overflow)
  );

  always #5 fq_clk = ~fq_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: an ordered list of {pc, instr} plus the sticky overflow bit.
  logic [63:0] model_q[$];
  logic        model_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One clock: drive inputs, check outputs before the edge, then advance the model.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic st, input logic fl, input logic rs = 1'b0);
    logic        e_valid;
    logic [63:0] e_head;
    int          sz;
    @(negedge fq_clk);
    fq_rst = rs; fq_i_valid = v; fq_i_pc = pc; fq_i_instr = instr;
    fq_i_stall = st; fq_i_flush = fl;
    #1;
    sz      = model_q.size();
    e_valid = (sz != 0);
    e_head  = (sz != 0) ? model_q[0] : 64'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (sz == 0 && v && !fl) begin
      e_valid = 1'b1;
      e_head  = {pc, instr};
    end
`endif
    if (!rs) begin
      check("valid",    {63'h0, fq_o_valid},    {63'h0, e_valid});
      check("ready",    {63'h0, fq_o_ready},    {63'h0, (sz != DEPTH)});
      check("count",    64'(fq_o_count),        64'(sz));
      check("head",     {fq_o_pc, fq_o_instr},  e_head);
      check("overflow", {63'h0, fq_o_overflow}, {63'h0, model_ovf});
    end
    @(posedge fq_clk);
    if (rs) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (v && sz == DEPTH) model_ovf = 1'b1;
      if (fl) begin
        model_q.delete();
      end else begin
`ifdef FETCH_QUEUE_BYPASS_EN
        if (!(sz == 0 && v && !st)) begin
`else
        begin
`endif
          if (sz != 0 && !st) void'(model_q.pop_front());
          if (v && sz != DEPTH) model_q.push_back({pc, instr});
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic st = 1'b0);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, st, 1'b0);
  endtask

  logic [31:0] stream_instr [3] = '{32'h20080005, 32'h20090003, 32'h01095020};

  initial begin
    fq_rst = 1'b1; fq_i_valid = 1'b0; fq_i_pc = '0; fq_i_instr = '0;
    fq_i_stall = 1'b0; fq_i_flush = 1'b0;
    model_ovf = 1'b0;

    // Reset held for two cycles, then idle.
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Streaming with no stall.
    for (int i = 0; i < 3; i++) step(1'b1, 32'(4 * i), stream_instr[i], 1'b0, 1'b0);
    idle(2);

    // Fill under stall: fifth word overflows, head stays at pc 0.
    for (int i = 0; i < 5; i++) step(1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
    idle(2, 1'b1);
    idle(6);

    // Flush with three queued and a same-cycle push of pc 0x40.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
    step(1'b1, 32'h40, 32'hC0DE_0040, 1'b1, 1'b1);
    idle(2);

    // Continuous traffic across the pointer wrap.
    for (int i = 0; i < 10; i++) step(1'b1, 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
    idle(2);

    // Empty queue, no stall: zero-latency with bypass, one cycle without.
    step(1'b1, 32'h10, 32'h1234_5678, 1'b0, 1'b0);
    idle(2);

    // Randomized traffic, including occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) < 70), $urandom, $urandom,
           ($urandom_range(99) < 40), ($urandom_range(99) < 4),
           ($urandom_range(199) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
